logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Registered, handshaked front-end for the ALU's bitwise logic path.
- Accepts operand/op requests on a valid/ready input channel.
- Computes AND/OR/XOR/PASS, optionally inverted, through a 2-stage pipeline.
- Presents result, zero flag and a completed-op counter on a valid/ready output channel. It supplies the input/output registering the combinational logic gates rely on.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_WIDTH, 16, width of the saturating completed-operation counter (>=1).

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept request this cycle
- in_op  input  2  00=AND, 01=OR, 10=XOR, 11=PASS_A
- in_invert  input  1  invert computed result (NAND/NOR/XNOR/NOT_A)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  computed result
- out_zero  output  1  out_result == 0
- op_count  output  CNT_WIDTH  number of completed output handshakes, saturating

Behaviour:
- Reset is synchronous on rising clk with rst_n=0.
  - Clears s1_valid, s2_valid, out_result, out_zero and op_count to 0.
  - Stage-1 operand registers are also cleared.
  - in_ready is 1 in the first cycle after reset release.
  - Reset mid-operation discards all in-flight requests; no output handshake is produced for them.
- Input handshake: transfer occurs when in_valid && in_ready. Fields are sampled only on transfer.
- Output handshake: transfer occurs when out_valid && out_ready.
- Stage 1 (S1) registers op, invert, a and b on input transfer.
- Stage 2 (S2) registers the result.
  - Result = f(op, a, b), then bitwise inverted if invert=1.
  - out_zero is computed from the final (post-invert) result.
  - out_valid = s2_valid.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - s1_move = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Latency: a request accepted in cycle N is visible with out_valid=1 in cycle N+2 when no backpressure is applied.
- Throughput: one request per cycle sustained while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_result, out_zero and out_valid hold stable.
  - S1 holds, and in_ready=0 once S1 is occupied.
  - A maximum of 2 requests are in flight; none are dropped or duplicated.
- Simultaneous events:
  - An output transfer and an S1->S2 move in the same cycle load S2 with the new result; out_valid stays 1.
  - An input transfer and an S1 move in the same cycle load S1 with the new request.
- Ordering: results leave in strict acceptance order.
- op_count increments by 1 on each output transfer and saturates at 2^CNT_WIDTH-1; it does not wrap.
- Width rule: all logic ops are bitwise at WIDTH bits. PASS_A ignores in_b.
- No error conditions: all op encodings are legal.

Test Plan (WIDTH=8):
- Reset check: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, op_count=0, out_result=0x00. First cycle after release shows in_ready=1.
- Op sweep: a=0xF0, b=0x3C, out_ready=1, issue each op with invert=0 then 1 -> results in order:
  - AND: 0x30, then 0xCF
  - OR: 0xFC, then 0x03
  - XOR: 0xCC, then 0x33
  - PASS_A: 0xF0, then 0x0F
  - Each result arrives exactly 2 cycles after acceptance; op_count=8 at the end.
- Zero flag: AND a=0x0F, b=0xF0 -> result 0x00, out_zero=1. Same with invert=1 -> 0xFF, out_zero=0.
- Backpressure: stream 4 back-to-back XORs (a=0x01..0x04, b=0xFF) with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - out_result holds 0xFE stable.
  - After releasing out_ready: 0xFE, 0xFD, 0xFC, 0xFB in order, no loss or duplicates.
- Reset mid-flight: accept 2 requests, assert rst_n=0 for 1 cycle while out_ready=0 -> out_valid=0 next cycle, op_count=0, discarded results never appear.
- Counter saturation (CNT_WIDTH=2): complete 5 ops -> op_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage handshaked bitwise logic unit with saturating completion counter
module logic_unit_pipe #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_op,
   input  logic                 in_invert,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic                 out_zero,
   output logic [CNT_WIDTH-1:0] op_count
);

   localparam logic [1:0]           OP_AND  = 2'b00;
   localparam logic [1:0]           OP_OR   = 2'b01;
   localparam logic [1:0]           OP_XOR  = 2'b10;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                 s1_valid;
   logic [1:0]           s1_op;
   logic                 s1_invert;
   logic [WIDTH-1:0]     s1_a;
   logic [WIDTH-1:0]     s1_b;
   logic                 s2_valid;

   logic                 s2_free;
   logic                 s1_move;
   logic                 in_fire;
   logic                 out_fire;
   logic [WIDTH-1:0]     s1_raw;
   logic [WIDTH-1:0]     s1_result;

   // in_ready depends only on pipeline state and out_ready, never on in_valid
   assign s2_free  = !s2_valid || out_ready;
   assign s1_move  = s1_valid && s2_free;
   assign in_ready = !s1_valid || s2_free;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid && out_ready;

   assign out_valid = s2_valid;

   always_comb begin
      s1_raw = s1_a;
      case (s1_op)
         OP_AND:  s1_raw = s1_a & s1_b;
         OP_OR:   s1_raw = s1_a | s1_b;
         OP_XOR:  s1_raw = s1_a ^ s1_b;
         default: s1_raw = s1_a;
      endcase
      s1_result = s1_invert ? ~s1_raw : s1_raw;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= 2'b00;
         s1_invert <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
      end else if (in_fire) begin
         s1_valid  <= 1'b1;
         s1_op     <= in_op;
         s1_invert <= in_invert;
         s1_a      <= in_a;
         s1_b      <= in_b;
      end else if (s1_move) begin
         s1_valid  <= 1'b0;
      end
   end

   // S2 only loads when it is free, so a stalled result stays put
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
      end else if (s1_move) begin
         s2_valid   <= 1'b1;
         out_result <= s1_result;
         out_zero   <= (s1_result == '0);
      end else if (out_fire) begin
         s2_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (out_fire && (op_count != CNT_MAX)) begin
         op_count <= op_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - randomized and directed scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;

   typedef struct {
      logic [1:0] op;
      logic       inv;
      logic [7:0] a;
      logic [7:0] b;
   } req_t;

   typedef struct {
      logic [7:0] res;
      int         acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic        in_invert;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_result;
   logic        out_zero;
   logic [15:0] op_count;

   logic        s_in_valid;
   logic        s_in_ready;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [7:0]  s_out_result;
   logic        s_out_zero;
   logic [1:0]  s_op_count;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   cnt = 0;
   logic in_en = 1'b1;
   req_t req_q[$];
   exp_t exp_q[$];
   logic [7:0] got_q[$];
   logic       gotz_q[$];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_invert(in_invert),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .op_count(op_count)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(2'b01), .in_invert(1'b0),
      .in_a(8'h5A), .in_b(8'h00),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
      .out_zero(s_out_zero), .op_count(s_op_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ref_op(input req_t r);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) begin
         case (r.op)
            2'd0: v[i] = r.a[i] && r.b[i];
            2'd1: v[i] = r.a[i] || r.b[i];
            2'd2: v[i] = r.a[i] != r.b[i];
            default: v[i] = r.a[i];
         endcase
         if (r.inv) v[i] = !v[i];
      end
      return v;
   endfunction

   task automatic push_req(input logic [1:0] op, input logic inv, input logic [7:0] a, input logic [7:0] b);
      req_t r;
      r.op = op; r.inv = inv; r.a = a; r.b = b;
      req_q.push_back(r);
   endtask

   // One clock: drive, check against the in-flight model, then advance the model
   task automatic tick();
      int   k;
      logic ev;
      logic er;
      exp_t e;
      in_valid = in_en && (req_q.size() > 0);
      if (req_q.size() > 0) begin
         in_op = req_q[0].op; in_invert = req_q[0].inv; in_a = req_q[0].a; in_b = req_q[0].b;
      end
      #1;
      k  = exp_q.size();
      ev = (k > 0) && (exp_q[0].acc + 2 <= cyc);
      er = (k < 2) || out_ready;
      check("out_valid", 32'(out_valid), 32'(ev));
      check("in_ready", 32'(in_ready), 32'(er));
      check("op_count", 32'(op_count), 32'(cnt));
      if (ev) begin
         check("out_result", 32'(out_result), 32'(exp_q[0].res));
         check("out_zero", 32'(out_zero), 32'(exp_q[0].res == 8'h00));
      end
      if (!rst_n) begin
         exp_q.delete();
         cnt = 0;
      end else begin
         if (ev && out_ready) begin
            void'(exp_q.pop_front());
            if (cnt < 65535) cnt++;
            got_q.push_back(out_result);
            gotz_q.push_back(out_zero);
         end
         if (in_valid && er) begin
            e.res = ref_op(req_q[0]);
            e.acc = cyc;
            exp_q.push_back(e);
            void'(req_q.pop_front());
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_en = 1'b1;
      for (int i = 0; i < 60 && (req_q.size() > 0 || exp_q.size() > 0); i++) tick();
      check("drain_left", 32'(req_q.size() + exp_q.size()), 32'd0);
   endtask

   logic [7:0] sweep_exp [8] = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'hF0, 8'h0F};
   logic [7:0] bp_exp [4]    = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_invert = 1'b0;
      in_a = 8'hAA; in_b = 8'h55; out_ready = 1'b0;
      s_in_valid = 1'b0; s_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_out_result", 32'(out_result), 32'h00);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_sat_count", 32'(s_op_count), 32'd0);

      // Op sweep, each op plain then inverted
      got_q.delete();
      for (int op = 0; op < 4; op++) begin
         push_req(2'(op), 1'b0, 8'hF0, 8'h3C);
         push_req(2'(op), 1'b1, 8'hF0, 8'h3C);
      end
      drain();
      check("sweep_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) check($sformatf("sweep_%0d", i), 32'(got_q[i]), 32'(sweep_exp[i]));
      check("sweep_op_count", 32'(op_count), 32'd8);

      // Zero flag
      got_q.delete(); gotz_q.delete();
      push_req(2'b00, 1'b0, 8'h0F, 8'hF0);
      push_req(2'b00, 1'b1, 8'h0F, 8'hF0);
      drain();
      check("zero_n", 32'(gotz_q.size()), 32'd2);
      if (gotz_q.size() == 2) begin
         check("zero_res0", 32'(got_q[0]), 32'h00);
         check("zero_flag0", 32'(gotz_q[0]), 32'd1);
         check("zero_res1", 32'(got_q[1]), 32'hFF);
         check("zero_flag1", 32'(gotz_q[1]), 32'd0);
      end

      // Backpressure: 4 XORs against a stalled sink
      got_q.delete();
      for (int i = 1; i <= 4; i++) push_req(2'b10, 1'b0, 8'(i), 8'hFF);
      out_ready = 1'b0;
      in_en = 1'b1;
      repeat (5) tick();
      check("bp_pending", 32'(req_q.size()), 32'd2);
      check("bp_hold", 32'(out_result), 32'hFE);
      drain();
      check("bp_n", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) check($sformatf("bp_%0d", i), 32'(got_q[i]), 32'(bp_exp[i]));

      // Reset with two requests in flight
      got_q.delete();
      push_req(2'b01, 1'b0, 8'h11, 8'h22);
      push_req(2'b01, 1'b0, 8'h33, 8'h44);
      out_ready = 1'b0;
      tick(); tick();
      check("mid_accepts", 32'(req_q.size()), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_op_count", 32'(op_count), 32'd0);
      out_ready = 1'b1;
      repeat (4) tick();
      check("mid_discarded", 32'(got_q.size()), 32'd0);

      // Random traffic with random stalls on both sides
      for (int i = 0; i < 300; i++)
         push_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 1500 && req_q.size() > 0; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_en     = ($urandom_range(0, 4) != 0);
         tick();
      end
      drain();

      // Saturation on the 2-bit counter instance
      s_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int w;
         s_in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         s_in_valid = 1'b0;
         w = 0;
         while (!s_out_valid && w < 10) begin
            @(posedge clk); @(negedge clk);
            w++;
         end
         check($sformatf("sat_wait_%0d", i), 32'(s_out_valid), 32'd1);
         @(posedge clk); @(negedge clk);
         check($sformatf("sat_count_%0d", i), 32'(s_op_count), 32'((i + 1 > 3) ? 3 : i + 1));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
